// File: rtl/flow_sequencer_pkg.sv
// flow_sequencer_pkg: opcode patterns, micro-op codes and FSM state encoding shared by the flow sequencer
package flow_sequencer_pkg;
  typedef logic [2:0] uop_t;
  localparam logic [4:0] OP_CALL = 5'b11100, OP_RET = 5'b11101, OP_INT = 5'b11110,
                         OP_RTI = 5'b11111, OP_HLT = 5'b00001;
  localparam uop_t UOP_NONE = 3'd0, UOP_PUSH_PC = 3'd1, UOP_PUSH_FLAGS = 3'd2, UOP_POP_PC = 3'd3,
                   UOP_POP_FLAGS = 3'd4, UOP_LD_VEC = 3'd5, UOP_JMP_RDST = 3'd6;
  localparam logic [2:0] S_IDLE = 3'd0, S_CALL_J = 3'd1, S_INT_F = 3'd2, S_INT_V = 3'd3,
                         S_RTI_P = 3'd4, S_DRAIN = 3'd5, S_HALT = 3'd6;
  function automatic logic is_flow_op(input logic [6:0] op);
    return op[6:2] inside {OP_CALL, OP_RET, OP_INT, OP_RTI, OP_HLT};
  endfunction
endpackage

// File: rtl/flow_sequencer_if.sv
// flow_sequencer_if: decode-side inputs and stall/micro-op outputs of the flow sequencer
interface flow_sequencer_if #(parameter int PC_W = 32);
  import flow_sequencer_pkg::*;
  logic id_valid;
  logic [6:0] id_opcode;
  logic [PC_W-1:0] id_pc;
  logic id_flush;
  logic ext_int;
  logic stall_if;
  logic kill_id;
  logic uop_valid;
  uop_t uop;
  logic [PC_W-1:0] uop_pc;
  logic [1:0] uop_vec;
  logic int_ack;
  logic halted;
  modport master (
    input  id_valid, id_opcode, id_pc, id_flush, ext_int,
    output stall_if, kill_id, uop_valid, uop, uop_pc, uop_vec, int_ack, halted
  );
  modport slave (
    output id_valid, id_opcode, id_pc, id_flush, ext_int,
    input  stall_if, kill_id, uop_valid, uop, uop_pc, uop_vec, int_ack, halted
  );
endinterface

// File: rtl/flow_sequencer_int_pending_latch.sv
// int_pending_latch: holds an external interrupt request until the sequencer is ready to take it
module int_pending_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_ready,
  output logic o_ack
);
  logic r_pend;
  assign o_ack = r_pend && i_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pend <= 1'b0;
    else r_pend <= i_set || (r_pend && !o_ack);
endmodule

// File: rtl/flow_sequencer.sv
// flow_sequencer: stalls fetch and injects micro-op sequences for CALL/RET/INT/RTI/HLT and external interrupts
module flow_sequencer
  import flow_sequencer_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int DRAIN = 3,
  parameter logic [1:0] EXT_VEC = 2'd0
) (
  input logic clk,
  input logic rst_n,
  flow_sequencer_if.master bus
);
  localparam int CW = DRAIN > 0 ? $clog2(DRAIN + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DRAIN);
  logic [2:0] r_state;
  uop_t r_uop;
  logic r_valid;
  logic [PC_W-1:0] r_pc;
  logic [1:0] r_vec;
  logic [CW-1:0] r_cnt;
  logic [4:0] w_op;
  logic [PC_W-1:0] w_pc_inc;
  logic w_idle, w_trig, w_ready, w_ack;
  assign w_op = bus.id_opcode[6:2];
  assign w_pc_inc = bus.id_pc + PC_W'(1);
  assign w_idle = r_state == S_IDLE;
  assign w_trig = w_idle && bus.id_valid && !bus.id_flush && is_flow_op(bus.id_opcode);
  assign w_ready = (w_idle && !w_trig) || r_state == S_HALT;
  int_pending_latch u_pend (
    .clk(clk),
    .rst_n(rst_n),
    .i_set(bus.ext_int),
    .i_ready(w_ready),
    .o_ack(w_ack)
  );
  assign bus.stall_if = !w_idle || w_trig || w_ack;
  assign bus.kill_id = (w_trig && w_op != OP_HLT) || (w_ack && w_idle && bus.id_valid);
  assign bus.int_ack = w_ack;
  assign bus.halted = r_state == S_HALT;
  assign bus.uop_valid = r_valid;
  assign bus.uop = r_uop;
  assign bus.uop_pc = r_pc;
  assign bus.uop_vec = r_vec;
  // DRAIN is entered on the cycle the last micro-op is visible, so it lasts DRAIN+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_uop <= UOP_NONE;
      r_valid <= 1'b0;
      r_pc <= '0;
      r_vec <= '0;
      r_cnt <= '0;
    end else begin
      r_uop <= UOP_NONE;
      r_valid <= 1'b0;
      r_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_pc <= w_pc_inc;
            r_vec <= bus.id_opcode[1:0];
            r_valid <= w_op != OP_HLT;
            r_uop <= w_op == OP_RET ? UOP_POP_PC : w_op == OP_RTI ? UOP_POP_FLAGS :
                     w_op == OP_HLT ? UOP_NONE : UOP_PUSH_PC;
            r_state <= w_op == OP_CALL ? S_CALL_J : w_op == OP_INT ? S_INT_F :
                       w_op == OP_RTI ? S_RTI_P : w_op == OP_RET ? S_DRAIN : S_HALT;
          end else if (w_ack) begin
            r_pc <= bus.id_pc;
            r_vec <= EXT_VEC;
            r_valid <= 1'b1;
            r_uop <= UOP_PUSH_PC;
            r_state <= S_INT_F;
          end
        end
        S_CALL_J: begin
          r_valid <= 1'b1;
          r_uop <= UOP_JMP_RDST;
          r_cnt <= CMAX;
          r_state <= S_DRAIN;
        end
        S_INT_F: begin
          r_valid <= 1'b1;
          r_uop <= UOP_PUSH_FLAGS;
          r_state <= S_INT_V;
        end
        S_INT_V: begin
          r_valid <= 1'b1;
          r_uop <= UOP_LD_VEC;
          r_state <= S_DRAIN;
        end
        S_RTI_P: begin
          r_valid <= 1'b1;
          r_uop <= UOP_POP_PC;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CMAX) r_state <= S_IDLE;
        end
        S_HALT: begin
          if (w_ack) begin
            r_vec <= EXT_VEC;
            r_valid <= 1'b1;
            r_uop <= UOP_PUSH_PC;
            r_state <= S_INT_F;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/flow_sequencer.md
# flow_sequencer

Multi-cycle sequencer for control-flow operations the single-cycle decode marks as NOP: CALL, RET, INT, RTI, HLT and external interrupts. Sits beside the decode stage. Stalls fetch and injects a fixed micro-op sequence into the ID/EX boundary for stack push/pop, vector load and PC redirect. Then waits for the pipeline to drain before releasing fetch.

## Interface
- PC_W, 32, PC and stack-value width
- DRAIN, 3, cycles waited after the last memory-sourced PC update (ID→WB depth)
- EXT_VEC, 2'd0, vector index used for external interrupts
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  7  opcode in ID
- id_pc  in  PC_W  PC of the ID instruction
- id_flush  in  1  ID instruction squashed this cycle (taken branch in EX)
- ext_int  in  1  external interrupt request, one-cycle pulse
- stall_if  out  1  hold PC and IF/ID register
- kill_id  out  1  convert ID instruction to bubble
- uop_valid  out  1  micro-op injected this cycle
- uop  out  3  0 NONE, 1 PUSH_PC, 2 PUSH_FLAGS, 3 POP_PC, 4 POP_FLAGS, 5 LD_VEC, 6 JMP_RDST
- uop_pc  out  PC_W  value written by PUSH_PC
- uop_vec  out  2  vector index for LD_VEC
- int_ack  out  1  one-cycle pulse, external interrupt accepted
- halted  out  1  core halted

## Operation
- Trigger condition: id_valid && !id_flush && state==IDLE. Trigger opcodes are CALL 11100??, RET 11101??, INT 11110vv, RTI 11111??, HLT 00001??.
- pend latch: set by ext_int, cleared at acceptance. A pulse arriving in the same cycle as acceptance is not lost; it re-sets pend.
- States: IDLE, CALL_J, INT_F, INT_V, RTI_P, DRAIN, HALT.
- CALL: PUSH_PC (uop_pc=id_pc+1), then JMP_RDST, then IDLE.
- INT: PUSH_PC (id_pc+1), PUSH_FLAGS, LD_VEC (uop_vec=vv), then DRAIN.
- RET: POP_PC, then DRAIN.
- RTI: POP_FLAGS, POP_PC, then DRAIN.
- HLT: goes to HALT. In HALT, stall_if=1 and halted=1. Stays in HALT until pend is set.
  - When pend is set, perform the INT sequence with uop_pc = halt PC+1 and uop_vec=EXT_VEC.
  - halted drops on the cycle that PUSH_PC is issued.
- External interrupt in IDLE:
  - Accepted when pend is set and no trigger opcode is in ID.
  - kill_id=1 that cycle if id_valid.
  - Runs the INT sequence with uop_pc=id_pc (the squashed instruction re-executes) and uop_vec=EXT_VEC.
  - If id_valid=0, uop_pc=id_pc still; IF/ID holds the next PC.
- Priority in IDLE: trigger opcode > pend. pend waits through any sequence, including DRAIN.
- DRAIN: count DRAIN cycles with uop_valid=0, then go to IDLE. pend is not accepted before IDLE.
- Width rules: id_pc+1 wraps modulo 2^PC_W. uop_vec = id_opcode[1:0].

## Timing
- Reset: state=IDLE, pend=0. All outputs 0; uop=NONE, uop_pc=0, uop_vec=0.
- stall_if is combinational: (state!=IDLE) || trigger || accept. It rises in trigger cycle T.
- uop, uop_valid, uop_pc and uop_vec are registered. The first micro-op appears at T+1, and one micro-op is issued per cycle.
- The trigger instruction itself is consumed at T. kill_id=1 at T for all triggers except HLT, so the original NOP-coded op never reaches EX twice.
- stall_if falls on the cycle the state returns to IDLE.
- int_ack is issued at T on acceptance.
- Cycle counts (T through the last stalled cycle):
  - CALL: 3 cycles.
  - RET: 2+DRAIN cycles.
  - RTI: 3+DRAIN cycles.
  - INT: 4+DRAIN cycles.
- id_flush=1 at T prevents the trigger, and no state change occurs. id_flush while not IDLE is ignored.
- Reset mid-sequence: immediately return to IDLE and clear outputs. Any partial stack effects are discarded by the datapath's own reset.

## Structure
- Shared control package holds the opcode patterns (CALL/RET/INT/RTI/HLT), the uop encoding constants and the state encoding.
- Sub-module int_pending_latch: the pend set/clear latch plus int_ack generation.
- Everything else lives in one FSM with a DRAIN counter of width $clog2(DRAIN+1).

## Test plan
- CALL at id_pc=0x10 → T+1 PUSH_PC with uop_pc=0x11; T+2 JMP_RDST; stall_if high for exactly 3 cycles; kill_id at T.
- INT opcode 1111010 at id_pc=0x40, DRAIN=3 → PUSH_PC 0x41, PUSH_FLAGS, LD_VEC with vec=2; then 3 idle cycles; stall_if high for 7 cycles.
- RTI followed by RET → POP_FLAGS, POP_PC, drain; then POP_PC, drain; no overlap between the two sequences.
- ext_int pulse during a RET drain → int_ack only on the first IDLE cycle; PUSH_PC pushes that cycle's id_pc; vec=EXT_VEC.
- HLT at 0x20 → halted=1 indefinitely; ext_int → PUSH_PC 0x21, PUSH_FLAGS, LD_VEC 0; halted clears.
- CALL with id_flush=1 → no stall, no uop. rst_n low mid-INT → all outputs 0 asynchronously.
